// File: rtl/regfile_checker_if.sv
// regfile_checker_if: register-file read port and expected-value table port seen by the checker
interface regfile_checker_if #(
  parameter int XLEN = 32,
  parameter int AW = 5
);
  logic [AW-1:0] rf_raddr, exp_addr;
  logic [XLEN-1:0] rf_rdata, exp_data;
  modport master (output rf_raddr, exp_addr, input rf_rdata, exp_data);
  modport slave (input rf_raddr, exp_addr, output rf_rdata, exp_data);
endinterface

// File: rtl/regfile_checker.sv
// regfile_checker: resets and runs a core, then scans its register file against expected values; REGCHK_HALT_ON_FAIL_EN ends the scan at the first mismatch
module regfile_checker #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 20,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic core_reset,
  regfile_checker_if.master bus,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] pass_count,
  output logic fail_valid,
  output logic [AW-1:0] fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [XLEN-1:0] fail_exp,
  output logic all_pass
);
`ifdef REGCHK_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, RST, RUN, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d, fail_idx_q, fail_idx_d;
  logic [CNT_W-1:0] test_q, test_d, pass_q, pass_d;
  logic fail_valid_q, fail_valid_d;
  logic [XLEN-1:0] fail_got_q, fail_got_d, fail_exp_q, fail_exp_d;
  logic chk, hit, miss, last;
  assign chk = state_q == SCAN && bus.exp_data != '0;
  assign hit = chk && bus.rf_rdata == bus.exp_data;
  assign miss = chk && bus.rf_rdata != bus.exp_data;
  assign last = idx_q == AW'(NREGS - 1);
  // state register; reset drops straight back to IDLE from anywhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: timed reset/run phases, then one index per cycle until the last (or first miss when halting)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? RST : IDLE;
      RST: state_d = (cnt_q == 16'(RST_CYCLES - 1)) ? RUN : RST;
      RUN: state_d = (cnt_q == 16'(RUN_CYCLES - 1)) ? SCAN : RUN;
      SCAN: state_d = (last || (HALT && miss)) ? DONE : SCAN;
      DONE: state_d = start ? RST : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state-decoded outputs; both table ports always look at the same index
  always_comb begin
    core_reset = state_q == IDLE || state_q == RST;
    busy = state_q == RST || state_q == RUN || state_q == SCAN;
    done = state_q == DONE;
    bus.rf_raddr = state_q == SCAN ? idx_q : '0;
    bus.exp_addr = state_q == SCAN ? idx_q : '0;
  end
  // datapath next values: phase timer, scan index, saturating counters, mismatch capture
  always_comb begin
    cnt_d = state_d != state_q ? '0 : cnt_q + 16'd1;
    idx_d = state_q == SCAN ? idx_q + AW'(1) : AW'(1);
    test_d = clear ? '0 : (chk && !(&test_q)) ? test_q + CNT_W'(1) : test_q;
    pass_d = clear ? '0 : (hit && !(&pass_q)) ? pass_q + CNT_W'(1) : pass_q;
    fail_valid_d = miss;
    fail_idx_d = miss ? idx_q : fail_idx_q;
    fail_got_d = miss ? bus.rf_rdata : fail_got_q;
    fail_exp_d = miss ? bus.exp_data : fail_exp_q;
  end
  // datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      test_q <= '0;
      pass_q <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      fail_exp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      test_q <= test_d;
      pass_q <= pass_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      fail_exp_q <= fail_exp_d;
    end
  end
  assign test_count = test_q;
  assign pass_count = pass_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx = fail_idx_q;
  assign fail_got = fail_got_q;
  assign fail_exp = fail_exp_q;
  assign all_pass = pass_q == test_q;
endmodule

// File: tb/tb_regfile_checker.sv
// tb_regfile_checker: directed and random scans of regfile_checker against a per-register reference model
module tb_regfile_checker;
  localparam int XLEN = 32, NREGS = 32, RSTC = 2, RUNC = 20, CNT_W = 6, AW = 5;
  localparam int SMAX = (1 << CNT_W) - 1;
`ifdef REGCHK_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  logic clk = 0, reset = 0, start = 0, clear = 0;
  logic core_reset, busy, done, fail_valid, all_pass;
  logic [CNT_W-1:0] test_count, pass_count;
  logic [AW-1:0] fail_idx;
  logic [XLEN-1:0] fail_got, fail_exp;
  logic [XLEN-1:0] rf_mem [NREGS];
  logic [XLEN-1:0] exp_mem [NREGS];
  int n_cmp = 0, n_bad = 0, mt = 0, mp = 0;

  regfile_checker_if #(.XLEN(XLEN), .AW(AW)) bus ();
  assign bus.rf_rdata = rf_mem[bus.rf_raddr];
  assign bus.exp_data = exp_mem[bus.exp_addr];

  regfile_checker #(.XLEN(XLEN), .NREGS(NREGS), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .core_reset(core_reset), .bus(bus),
    .busy(busy), .done(done), .test_count(test_count), .pass_count(pass_count), .fail_valid(fail_valid),
    .fail_idx(fail_idx), .fail_got(fail_got), .fail_exp(fail_exp), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return x > SMAX ? SMAX : x;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/idle"}, {core_reset, busy, done, fail_valid, bus.rf_raddr, bus.exp_addr}, {4'b1000, 10'd0});
  endtask

  // one start-to-done run; st_cyc re-pulses start, clr_cyc pulses clear, abort_cyc pulls reset (0 = unused)
  task automatic run(input string tag, input int st_cyc, input int clr_cyc, input int abort_cyc);
    int lat, seen, a;
    logic [71:0] eq[$], oq[$];
    lat = RSTC + RUNC + NREGS;
    for (int i = 1; i < NREGS; i++) begin
      if (exp_mem[i] != 0) begin
        mt = sat(mt + 1);
        if (rf_mem[i] == exp_mem[i]) mp = sat(mp + 1);
        else begin
          eq.push_back({8'(i), rf_mem[i], exp_mem[i]});
          if (HALT) begin
            lat = RSTC + RUNC + 1 + i;
            break;
          end
        end
      end
      if (i == clr_cyc - (RSTC + RUNC)) begin
        mt = 0;
        mp = 0;
      end
    end
    start = 1;
    seen = 0;
    for (int c = 1; c <= 300 && seen == 0; c++) begin
      @(negedge clk);
      start = (c == st_cyc);
      clear = (c == clr_cyc);
      if (c == abort_cyc) begin
        reset = 0;
        #1;
        check({tag, "/abort"}, {core_reset, busy, done, fail_valid, bus.rf_raddr, test_count, pass_count, fail_idx, fail_got, fail_exp},
              {4'b1000, 5'd0, 12'd0, 5'd0, 64'd0});
        mt = 0;
        mp = 0;
        return;
      end
      a = (c > RSTC + RUNC && c < lat) ? c - (RSTC + RUNC) : 0;
      check({tag, "/cycle"}, {core_reset, busy, done, bus.rf_raddr, bus.exp_addr},
            {c <= RSTC, c < lat, c == lat, 5'(a), 5'(a)});
      if (fail_valid) oq.push_back({8'(fail_idx), fail_got, fail_exp});
      if (done) seen = c;
    end
    check({tag, "/latency"}, seen, lat);
    check({tag, "/test_count"}, test_count, mt);
    check({tag, "/pass_count"}, pass_count, mp);
    check({tag, "/all_pass"}, all_pass, mt == mp);
    check({tag, "/strobes"}, oq.size(), eq.size());
    for (int k = 0; k < eq.size() && k < oq.size(); k++) check({tag, "/fail_data"}, oq[k], eq[k]);
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
    mt = 0;
    mp = 0;
    check("clear", {test_count, pass_count, all_pass}, {12'd0, 1'b1});
  endtask

  task automatic fill_five();
    for (int i = 0; i < NREGS; i++) begin
      rf_mem[i] = $urandom;
      exp_mem[i] = 0;
    end
    for (int i = 1; i <= 5; i++) begin
      exp_mem[i] = $urandom | 32'h1;
      rf_mem[i] = exp_mem[i];
    end
  endtask

  task automatic fill_match();
    for (int i = 0; i < NREGS; i++) begin
      exp_mem[i] = $urandom | 32'h100;
      rf_mem[i] = exp_mem[i];
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      rf_mem[i] = 0;
      exp_mem[i] = 0;
    end
    @(negedge clk);
    check("reset_state", {core_reset, busy, done, fail_valid, all_pass, bus.rf_raddr, bus.exp_addr, test_count, pass_count, fail_idx, fail_got, fail_exp},
          {5'b10001, 10'd0, 12'd0, 5'd0, 64'd0});
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      check_idle("post_reset");
    end
    fill_five();
    run("five_pass", 0, 0, 0);
    check("five_tests", test_count, 5);
    do_clear();
    fill_match();
    exp_mem[7] = 32'h0000000A;
    rf_mem[7] = 32'h0000000B;
    run("x7_miss", 0, 0, 0);
    check("x7_fail_regs", {fail_idx, fail_got, fail_exp}, {5'd7, 32'h0000000B, 32'h0000000A});
    do_clear();
    fill_match();
    rf_mem[3] = ~exp_mem[3];
    rf_mem[9] = exp_mem[9] ^ 32'h40;
    run("x3_x9_miss", 0, 0, 0);
    do_clear();
    fill_five();
    run("accum_a", 0, 0, 0);
    run("accum_b", 0, 0, 0);
    check("accum_ten", test_count, 10);
    run("clear_on_pass", 0, RSTC + RUNC + 5, 0);
    check("clear_won", {test_count, pass_count}, 12'd0);
    run("start_in_run", 10, 0, 0);
    run("start_in_scan", RSTC + RUNC + 4, 0, 0);
    fill_match();
    run("abort_scan", 0, 0, RSTC + RUNC + 12);
    @(negedge clk);
    reset = 1;
    repeat (2) begin
      @(negedge clk);
      check_idle("after_abort");
    end
    run("rerun", 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREGS; i++) begin
        exp_mem[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        rf_mem[i] = ($urandom_range(0, 5) == 0) ? exp_mem[i] ^ (32'd1 << $urandom_range(0, 31)) : exp_mem[i];
      end
      run("random", 0, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
